// File: rtl/lynxTypes.sv
// Shared types and defaults for the dynamic-region decoupler.
package lynxTypes;

  typedef enum logic [1:0] {
    DCPL_IDLE     = 2'd0,
    DCPL_DRAIN    = 2'd1,
    DCPL_QUIESCED = 2'd2
  } dcpl_state_t;

  localparam int DCPL_OUTST_BITS   = 6;
  localparam int DCPL_TIMEOUT      = 65535;
  localparam int DCPL_TIMEOUT_BITS = 16;

endpackage

// File: rtl/dcpl_dynamic_drain_if.sv
// Handshake bundle of one user stream channel: DMA rd/wr requests plus both AXIS directions.
interface dcpl_dynamic_drain_if;

  logic s_rd_valid, s_rd_ready, m_rd_valid, m_rd_ready, rd_done;
  logic s_wr_valid, s_wr_ready, m_wr_valid, m_wr_ready, wr_done;
  logic s_out_tvalid, s_out_tready, s_out_tlast;
  logic m_out_tvalid, m_out_tready, m_out_tlast;
  logic s_in_tvalid, s_in_tready, s_in_tlast;
  logic m_in_tvalid, m_in_tready, m_in_tlast;

  // slave: the drain block; master: the user logic and shell around it.
  modport slave (
    input  s_rd_valid, m_rd_ready, rd_done,
    input  s_wr_valid, m_wr_ready, wr_done,
    input  s_out_tvalid, s_out_tlast, m_out_tready,
    input  s_in_tvalid, s_in_tlast, m_in_tready,
    output s_rd_ready, m_rd_valid, s_wr_ready, m_wr_valid,
    output s_out_tready, m_out_tvalid, m_out_tlast,
    output s_in_tready, m_in_tvalid, m_in_tlast
  );

  modport master (
    output s_rd_valid, m_rd_ready, rd_done,
    output s_wr_valid, m_wr_ready, wr_done,
    output s_out_tvalid, s_out_tlast, m_out_tready,
    output s_in_tvalid, s_in_tlast, m_in_tready,
    input  s_rd_ready, m_rd_valid, s_wr_ready, m_wr_valid,
    input  s_out_tready, m_out_tvalid, m_out_tlast,
    input  s_in_tready, m_in_tvalid, m_in_tlast
  );

endinterface

// File: rtl/dcpl_pkt_tracker.sv
// Tracks whether an AXIS packet is open and blocks new packet starts while gated.
module dcpl_pkt_tracker (
  input  logic aclk,
  input  logic aresetn,
  input  logic gate_i,
  input  logic s_tvalid_i,
  output logic s_tready_o,
  input  logic s_tlast_i,
  output logic m_tvalid_o,
  input  logic m_tready_i,
  output logic m_tlast_o,
  output logic mid_o
);

  logic mid_q, mid_d;
  logic block, beat;

  // An open packet is never cut: only a start (mid = 0) is held back.
  assign block      = gate_i & ~mid_q;
  assign m_tvalid_o = s_tvalid_i & ~block;
  assign s_tready_o = m_tready_i & ~block;
  assign m_tlast_o  = s_tlast_i;
  assign beat       = m_tvalid_o & m_tready_i;
  assign mid_d      = beat ? ~s_tlast_i : mid_q;
  assign mid_o      = mid_q;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) mid_q <= 1'b0;
    else          mid_q <= mid_d;
  end

endmodule

// File: rtl/dcpl_dynamic_drain.sv
// Quiesces one user stream channel on decouple_req before the static side isolates the region.
module dcpl_dynamic_drain
  import lynxTypes::*;
#(
  parameter int OUTST_BITS   = DCPL_OUTST_BITS,
  parameter int TIMEOUT      = DCPL_TIMEOUT,
  parameter int TIMEOUT_BITS = DCPL_TIMEOUT_BITS
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                decouple_req,
  output logic                decouple_ack,
  output logic                drain_timeout,
  dcpl_dynamic_drain_if.slave bus
);

  localparam logic [OUTST_BITS-1:0]   CNT_MAX     = '1;
  localparam logic [OUTST_BITS-1:0]   CNT_ONE     = OUTST_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] TIMER_ONE   = TIMEOUT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LIMIT = TIMEOUT_BITS'(TIMEOUT);

  dcpl_state_t             state_q, state_d;
  logic [OUTST_BITS-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d, timer_inc;
  logic                    ack_q, timeout_q, timeout_d;
  logic                    idle, rd_full, wr_full, rd_hs, wr_hs;
  logic                    out_mid, in_mid, drained, timer_expired;

  function automatic logic [OUTST_BITS-1:0] cnt_next(logic [OUTST_BITS-1:0] cnt,
                                                      logic inc, logic done);
    logic dec;
    dec = done & (cnt != '0);
    case ({inc, dec})
      2'b10:   cnt_next = cnt + CNT_ONE;
      2'b01:   cnt_next = cnt - CNT_ONE;
      default: cnt_next = cnt;
    endcase
  endfunction

  // Gating follows the registered state, so a handshake in the req-rise cycle still counts.
  assign idle    = (state_q == DCPL_IDLE);
  assign rd_full = (rd_cnt_q == CNT_MAX);
  assign wr_full = (wr_cnt_q == CNT_MAX);

  // valid is held back at full count too, so the shell never sees a request we cannot count.
  assign bus.m_rd_valid = idle & ~rd_full & bus.s_rd_valid;
  assign bus.s_rd_ready = idle & ~rd_full & bus.m_rd_ready;
  assign bus.m_wr_valid = idle & ~wr_full & bus.s_wr_valid;
  assign bus.s_wr_ready = idle & ~wr_full & bus.m_wr_ready;
  assign rd_hs          = bus.m_rd_valid & bus.m_rd_ready;
  assign wr_hs          = bus.m_wr_valid & bus.m_wr_ready;
  assign rd_cnt_d       = cnt_next(rd_cnt_q, rd_hs, bus.rd_done);
  assign wr_cnt_d       = cnt_next(wr_cnt_q, wr_hs, bus.wr_done);

  dcpl_pkt_tracker u_out_trk (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .gate_i     (~idle),
    .s_tvalid_i (bus.s_out_tvalid),
    .s_tready_o (bus.s_out_tready),
    .s_tlast_i  (bus.s_out_tlast),
    .m_tvalid_o (bus.m_out_tvalid),
    .m_tready_i (bus.m_out_tready),
    .m_tlast_o  (bus.m_out_tlast),
    .mid_o      (out_mid)
  );

  dcpl_pkt_tracker u_in_trk (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .gate_i     (~idle),
    .s_tvalid_i (bus.s_in_tvalid),
    .s_tready_o (bus.s_in_tready),
    .s_tlast_i  (bus.s_in_tlast),
    .m_tvalid_o (bus.m_in_tvalid),
    .m_tready_i (bus.m_in_tready),
    .m_tlast_o  (bus.m_in_tlast),
    .mid_o      (in_mid)
  );

  assign drained       = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !out_mid && !in_mid;
  assign timer_inc     = timer_q + TIMER_ONE;
  assign timer_expired = (TIMEOUT != 0) && (timer_inc == TIMER_LIMIT);

  // NOTE: every always_comb output is defaulted first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    unique case (state_q)
      DCPL_IDLE: begin
        if (decouple_req) begin
          state_d = DCPL_DRAIN;
          timer_d = '0;
        end
      end
      DCPL_DRAIN: begin
        timer_d = timer_inc;
        if (!decouple_req) state_d = DCPL_IDLE;
        else if (drained)  state_d = DCPL_QUIESCED;
        else if (timer_expired) begin
          state_d   = DCPL_QUIESCED;
          timeout_d = 1'b1;
        end
      end
      DCPL_QUIESCED: begin
        if (!decouple_req) state_d = DCPL_IDLE;
      end
      default: state_d = DCPL_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= DCPL_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      timer_q   <= timer_d;
      ack_q     <= (state_d == DCPL_QUIESCED);
      timeout_q <= timeout_d;
    end
  end

  assign decouple_ack  = ack_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_dcpl_dynamic_drain.sv
// Scoreboard bench for dcpl_dynamic_drain: stimulus queues per-cycle expectations, a monitor checks them.
module tb_dcpl_dynamic_drain;

  localparam int OUTST_BITS   = 6;
  localparam int TIMEOUT      = 16;
  localparam int TIMEOUT_BITS = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic decouple_req = 1'b0;
  logic decouple_ack, drain_timeout;

  dcpl_dynamic_drain_if bus ();

  dcpl_dynamic_drain #(
    .OUTST_BITS   (OUTST_BITS),
    .TIMEOUT      (TIMEOUT),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .decouple_req  (decouple_req),
    .decouple_ack  (decouple_ack),
    .drain_timeout (drain_timeout),
    .bus           (bus)
  );

  always #5 aclk = ~aclk;

  // -1 in any field means "not checked this cycle".
  typedef struct {
    string name;
    int ack; int to;
    int rd_rdy; int rd_vld; int wr_rdy; int wr_vld;
    int out_rdy; int out_vld; int in_rdy; int in_vld;
    int rd_cnt; int wr_cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e, mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t blank(string name);
    exp_t x;
    x.name = name;
    x.ack = -1; x.to = -1;
    x.rd_rdy = -1; x.rd_vld = -1; x.wr_rdy = -1; x.wr_vld = -1;
    x.out_rdy = -1; x.out_vld = -1; x.in_rdy = -1; x.in_vld = -1;
    x.rd_cnt = -1; x.wr_cnt = -1;
    return x;
  endfunction

  task automatic check(string nm, string fld, int act, int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(exp_t x);
    sb_q.push_back(x);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle against live outputs.
  always @(negedge aclk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.name, "ack",     int'(decouple_ack),         mon_e.ack);
      check(mon_e.name, "timeout", int'(drain_timeout),        mon_e.to);
      check(mon_e.name, "s_rd_ready",   int'(bus.s_rd_ready),   mon_e.rd_rdy);
      check(mon_e.name, "m_rd_valid",   int'(bus.m_rd_valid),   mon_e.rd_vld);
      check(mon_e.name, "s_wr_ready",   int'(bus.s_wr_ready),   mon_e.wr_rdy);
      check(mon_e.name, "m_wr_valid",   int'(bus.m_wr_valid),   mon_e.wr_vld);
      check(mon_e.name, "s_out_tready", int'(bus.s_out_tready), mon_e.out_rdy);
      check(mon_e.name, "m_out_tvalid", int'(bus.m_out_tvalid), mon_e.out_vld);
      check(mon_e.name, "s_in_tready",  int'(bus.s_in_tready),  mon_e.in_rdy);
      check(mon_e.name, "m_in_tvalid",  int'(bus.m_in_tvalid),  mon_e.in_vld);
      check(mon_e.name, "rd_cnt", int'(dut.rd_cnt_q), mon_e.rd_cnt);
      check(mon_e.name, "wr_cnt", int'(dut.wr_cnt_q), mon_e.wr_cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_rd_valid = 0; bus.m_rd_ready = 1; bus.rd_done = 0;
    bus.s_wr_valid = 0; bus.m_wr_ready = 1; bus.wr_done = 0;
    bus.s_out_tvalid = 0; bus.s_out_tlast = 0; bus.m_out_tready = 1;
    bus.s_in_tvalid = 0;  bus.s_in_tlast = 0;  bus.m_in_tready = 1;

    tick();
    e = blank("reset"); e.ack = 0; e.to = 0; e.rd_rdy = 1; e.rd_vld = 0; e.wr_rdy = 1;
    e.out_rdy = 1; e.in_rdy = 1; e.rd_cnt = 0; e.wr_cnt = 0; push(e);
    tick();
    aresetn = 1;
    tick();

    // 1) three reads outstanding, then drain via rd_done pulses
    bus.s_rd_valid = 1;
    e = blank("t1_rd_accept"); e.rd_vld = 1; e.rd_rdy = 1; e.rd_cnt = 0; push(e);
    tick(); tick(); tick();
    bus.s_rd_valid = 0; decouple_req = 1;
    e = blank("t1_req_rise"); e.ack = 0; e.rd_rdy = 1; e.rd_cnt = 3; push(e);
    tick();
    bus.s_rd_valid = 1;
    e = blank("t1_drain_gate"); e.ack = 0; e.rd_rdy = 0; e.rd_vld = 0;
    e.out_rdy = 0; e.in_rdy = 0; e.rd_cnt = 3; push(e);
    tick();
    bus.s_rd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_done = 1;
      e = blank("t1_done"); e.ack = 0; e.rd_cnt = 3 - i; push(e);
      tick();
    end
    bus.rd_done = 0;
    e = blank("t1_done_plus1"); e.ack = 0; e.rd_cnt = 0; push(e);
    tick();
    e = blank("t1_done_plus2"); e.ack = 1; e.rd_rdy = 0; push(e);
    tick();
    decouple_req = 0;
    e = blank("t5_q_req_drop"); e.ack = 1; push(e);
    tick();
    e = blank("t5_q_ack_fall"); e.ack = 0; e.rd_rdy = 1; push(e);
    tick();

    // 2) four-beat out packet, req raised after beat 2
    bus.s_out_tvalid = 1; bus.s_out_tlast = 0;
    e = blank("t2_beat1"); e.out_vld = 1; e.out_rdy = 1; push(e); tick();
    e = blank("t2_beat2"); e.out_vld = 1; push(e); tick();
    decouple_req = 1;
    e = blank("t2_beat3"); e.out_vld = 1; e.out_rdy = 1; push(e); tick();
    bus.s_out_tlast = 1;
    e = blank("t2_beat4"); e.out_vld = 1; e.out_rdy = 1; e.in_rdy = 0; e.ack = 0; push(e); tick();
    bus.s_out_tlast = 0;
    e = blank("t2_start_blocked"); e.out_vld = 0; e.out_rdy = 0; e.ack = 0; push(e); tick();
    e = blank("t2_ack"); e.ack = 1; e.out_vld = 0; push(e); tick();
    decouple_req = 0;
    e = blank("t2_req_drop"); e.ack = 1; e.out_vld = 0; push(e); tick();
    bus.s_out_tlast = 1;
    e = blank("t2_released"); e.ack = 0; e.out_vld = 1; e.out_rdy = 1; push(e); tick();
    bus.s_out_tvalid = 0; bus.s_out_tlast = 0;

    // 3) simultaneous inc/dec, then fill the write counter to its maximum
    bus.s_rd_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    bus.rd_done = 1;
    e = blank("t3_cnt5"); e.rd_cnt = 5; e.rd_rdy = 1; push(e); tick();
    bus.s_rd_valid = 0; bus.rd_done = 0;
    e = blank("t3_inc_dec_same"); e.rd_cnt = 5; push(e); tick();
    bus.s_wr_valid = 1;
    e = blank("t3_wr_first"); e.wr_rdy = 1; e.wr_vld = 1; e.wr_cnt = 0; push(e);
    for (int i = 0; i < 63; i++) tick();
    e = blank("t3_wr_full"); e.wr_cnt = 63; e.wr_rdy = 0; push(e); tick();
    e = blank("t3_wr_no_overflow"); e.wr_cnt = 63; e.wr_rdy = 0; push(e); tick();
    bus.s_wr_valid = 0;

    // 5) abort from DRAIN keeps counters and never acks
    decouple_req = 1;
    e = blank("t5_abort_req"); e.ack = 0; push(e); tick();
    decouple_req = 0;
    e = blank("t5_drain_gated"); e.rd_rdy = 0; e.ack = 0; push(e); tick();
    e = blank("t5_abort_release"); e.rd_rdy = 1; e.ack = 0; e.rd_cnt = 5; e.wr_cnt = 63; push(e); tick();
    e = blank("t5_abort_no_ack"); e.ack = 0; push(e); tick();
    bus.rd_done = 1;
    repeat (3) tick();
    bus.rd_done = 0;
    e = blank("t6_setup_rd2"); e.rd_cnt = 2; push(e); tick();

    // 4) timeout with a write that never completes
    decouple_req = 1;
    e = blank("t4_req"); e.ack = 0; push(e); tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 15) begin
        e = blank(i == 0 ? "t4_drain_first" : "t4_drain_last");
        e.ack = 0; e.to = 0; e.wr_rdy = 0; push(e);
      end
      tick();
    end
    e = blank("t4_timeout"); e.ack = 1; e.to = 1; e.rd_cnt = 2; e.wr_cnt = 63; push(e); tick();

    // 6) asynchronous reset while QUIESCED
    aresetn = 0;
    #1;
    e = blank("t6_async_reset"); e.ack = 0; e.to = 0; e.rd_cnt = 0; e.wr_cnt = 0;
    e.rd_rdy = 1; e.wr_rdy = 1; push(e);
    tick();
    decouple_req = 0;
    aresetn = 1;
    bus.rd_done = 1;
    e = blank("t6_after_reset"); e.ack = 0; e.to = 0; e.rd_cnt = 0; push(e); tick();
    bus.rd_done = 0;
    e = blank("t6_done_at_zero"); e.rd_cnt = 0; e.rd_rdy = 1; push(e); tick();

    // shell->user direction: open packet completes, next start blocked
    bus.s_in_tvalid = 1; bus.s_in_tlast = 0; decouple_req = 1;
    e = blank("t7_in_beat1"); e.in_vld = 1; e.in_rdy = 1; push(e); tick();
    bus.s_in_tlast = 1;
    e = blank("t7_in_last_passes"); e.in_vld = 1; e.in_rdy = 1; e.ack = 0; push(e); tick();
    bus.s_in_tlast = 0;
    e = blank("t7_in_start_blocked"); e.in_vld = 0; e.in_rdy = 0; e.ack = 0; push(e); tick();
    bus.s_in_tvalid = 0;
    e = blank("t7_in_ack"); e.ack = 1; e.to = 0; push(e); tick();
    decouple_req = 0;
    tick(); tick();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
